// File: rtl/throw_trajectory.sv
// throw_trajectory: charges launch power while fire is held, pulses throw_flag on release, then flies ypos_prebuff along a gravity arc until end_throw
//   clk60MHz      in   system clock
//   rst_n         in   asynchronous active-low reset
//   fire          in   power button level, 1 = held
//   end_throw     in   pulse from simulator: throw resolved, return to idle
//   throw_flag    out  one-cycle registered pulse on release of fire in CHARGE
//   speed         out  [4:0] current / latched launch power
//   ypos_prebuff  out  [11:0] projectile vertical position, pixels
//   busy          out  1 while charging or in flight
module throw_trajectory #(
  parameter int TICK_DIV   = 250000,
  parameter int CHARGE_DIV = 3000000,
  parameter int SPEED_MIN  = 1,
  parameter int SPEED_MAX  = 31,
  parameter int Y_START    = 384,
  parameter int Y_FLOOR    = 768,
  parameter int GRAVITY    = 1
) (
  input  logic        clk60MHz,
  input  logic        rst_n,
  input  logic        fire,
  input  logic        end_throw,
  output logic        throw_flag,
  output logic [4:0]  speed,
  output logic [11:0] ypos_prebuff,
  output logic        busy
);
  localparam int CW = $clog2(CHARGE_DIV + 1);
  localparam int TW = $clog2(TICK_DIV + 1);
  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_FLIGHT} state_t;
  state_t             r_state, w_state;
  logic               r_fire_d, r_armed, r_dir, w_dir;
  logic [CW-1:0]      r_cc, w_cc;
  logic [TW-1:0]      r_tc, w_tc;
  logic signed [7:0]  r_vy, w_vy;
  logic [4:0]         r_speed, w_speed, w_step;
  logic [11:0]        r_ypos, w_ypos, w_ynext;
  logic               r_flag, w_flag, r_busy;
  logic               w_rise, w_fall, w_wrap, w_tick;
  logic [12:0]        w_sum;
  logic signed [8:0]  w_vsum;
  // r_armed blocks a charge from a fire level already high when reset releases
  assign w_rise  = fire & ~r_fire_d & r_armed;
  assign w_fall  = ~fire & r_fire_d;
  assign w_wrap  = r_cc == CW'(CHARGE_DIV - 1);
  assign w_tick  = r_tc == TW'(TICK_DIV - 1);
  assign w_step  = r_dir ? r_speed - 5'd1 : r_speed + 5'd1;
  // bit 12 of the sum acts as the sign: positions never exceed 12 bits
  assign w_sum   = {1'b0, r_ypos} + {{5{r_vy[7]}}, r_vy};
  assign w_ynext = w_sum[12] ? 12'd0 : (w_sum[11:0] >= 12'(Y_FLOOR) ? 12'(Y_FLOOR) : w_sum[11:0]);
  assign w_vsum  = $signed({r_vy[7], r_vy}) + $signed(9'(GRAVITY));
  always_comb begin
    w_state = r_state;
    w_dir   = r_dir;
    w_cc    = r_cc;
    w_tc    = r_tc;
    w_vy    = r_vy;
    w_speed = r_speed;
    w_ypos  = r_ypos;
    w_flag  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ypos = 12'(Y_FLOOR);
        if (w_rise) begin
          w_state = S_CHARGE;
          w_speed = 5'(SPEED_MIN);
          w_cc    = '0;
          w_dir   = 1'b0;
        end
      end
      S_CHARGE: begin
        if (w_fall) begin
          w_state = S_FLIGHT;
          w_flag  = 1'b1;
          w_vy    = -$signed({3'b000, r_speed});
          w_ypos  = 12'(Y_START);
          w_tc    = '0;
        end else begin
          w_cc = w_wrap ? '0 : r_cc + 1'b1;
          if (w_wrap) begin
            w_speed = w_step;
            w_dir   = w_step == 5'(SPEED_MAX) ? 1'b1 : (w_step == 5'(SPEED_MIN) ? 1'b0 : r_dir);
          end
        end
      end
      S_FLIGHT: begin
        if (end_throw) begin
          w_state = S_IDLE;
          w_ypos  = 12'(Y_FLOOR);
        end else begin
          w_tc = w_tick ? '0 : r_tc + 1'b1;
          if (w_tick) begin
            w_ypos = w_ynext;
            w_vy   = w_vsum > 9'sd127 ? 8'sd127 : w_vsum[7:0];
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_fire_d <= 1'b0;
      r_armed  <= 1'b0;
      r_dir    <= 1'b0;
      r_cc     <= '0;
      r_tc     <= '0;
      r_vy     <= '0;
      r_speed  <= 5'(SPEED_MIN);
      r_ypos   <= 12'(Y_FLOOR);
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_fire_d <= fire;
      r_armed  <= r_armed | ~fire;
      r_dir    <= w_dir;
      r_cc     <= w_cc;
      r_tc     <= w_tc;
      r_vy     <= w_vy;
      r_speed  <= w_speed;
      r_ypos   <= w_ypos;
      r_flag   <= w_flag;
      r_busy   <= w_state != S_IDLE;
    end
  end
  assign throw_flag   = r_flag;
  assign speed        = r_speed;
  assign ypos_prebuff = r_ypos;
  assign busy         = r_busy;
endmodule

// File: tb/tb_throw_trajectory.sv
// tb_throw_trajectory: randomized and directed throws checked against an arithmetic trajectory model
module tb_throw_trajectory;
  localparam int TD = 4;
  localparam int CD = 2;
  logic        clk = 0, rst_n = 0, fire = 0, end_throw = 0;
  logic        throw_flag, busy;
  logic [4:0]  speed;
  logic [11:0] ypos_prebuff;
  int vecs = 0, errs = 0;
  throw_trajectory #(.TICK_DIV(TD), .CHARGE_DIV(CD)) dut (
    .clk60MHz(clk), .rst_n(rst_n), .fire(fire), .end_throw(end_throw),
    .throw_flag(throw_flag), .speed(speed), .ypos_prebuff(ypos_prebuff), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int spd(input int w);
    int p = w % 60;
    return p <= 30 ? 1 + p : 61 - p;
  endfunction
  task automatic idle_chk(input string tag, input int s);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_y"}, ypos_prebuff, 768);
    chk({tag, "_flag"}, throw_flag, 0);
    chk({tag, "_speed"}, speed, s);
  endtask
  // hold fire for n sampled edges, fly for 'flight' edges, then end_throw on the next edge
  task automatic do_throw(input int n, input int flight, input bit jitter, output int s);
    int y, vy;
    fire = 1;
    tick();
    chk("charge_busy", busy, 1);
    chk("charge_speed0", speed, 1);
    for (int j = 1; j < n; j++) begin
      end_throw = jitter ? 1'($urandom) : 1'b0;
      tick();
      chk("charge_speed", speed, spd(j / CD));
      chk("charge_busy", busy, 1);
      chk("charge_flag", throw_flag, 0);
    end
    end_throw = 0;
    fire = 0;
    tick();
    s = spd((n - 1) / CD);
    chk("flag_pulse", throw_flag, 1);
    chk("launch_speed", speed, s);
    chk("launch_y", ypos_prebuff, 384);
    y = 384;
    vy = -s;
    for (int m = 1; m <= flight; m++) begin
      fire = jitter ? 1'($urandom) : 1'b0;
      tick();
      if (m % TD == 0) begin
        y = y + vy;
        y = y < 0 ? 0 : (y >= 768 ? 768 : y);
        vy = vy + 1 > 127 ? 127 : vy + 1;
      end
      chk("flight_y", ypos_prebuff, y);
      chk("flight_flag", throw_flag, 0);
      chk("flight_speed", speed, s);
      chk("flight_busy", busy, 1);
    end
    fire = 0;
    end_throw = 1;
    tick();
    end_throw = 0;
    idle_chk("end", s);
  endtask
  initial begin
    int s, n;
    fire = 1;
    #12;
    idle_chk("reset", 1);
    tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      idle_chk("held_after_reset", 1);
    end
    fire = 0;
    tick();
    idle_chk("fire_drop", 1);
    do_throw(11, 40, 0, s);
    chk("speed6", s, 6);
    do_throw(70, 30, 0, s);
    do_throw(61, 400, 0, s);
    do_throw(5, 4 * 6 - 1, 0, s);
    for (int i = 0; i < 3; i++) begin
      end_throw = 1;
      tick();
      end_throw = 0;
      idle_chk("idle_end_throw", s);
    end
    for (int i = 0; i < 6; i++) begin
      n = $urandom_range(1, 90);
      do_throw(n, $urandom_range(5, 300), 1, s);
      tick();
    end
    fire = 1;
    for (int i = 0; i < 9; i++) tick();
    fire = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    idle_chk("async_reset", 1);
    tick();
    idle_chk("in_reset", 1);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      idle_chk("after_reset", 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
